four_bit_adder: RTL and testbench

4-bit ripple-carry adder with carry-in. Built as a chain of four 1-bit full-adder cells.
- Provides combinational sum/carry outputs for immediate use.
- Provides a registered copy of the result for pipelined datapaths.
- Sits in the arithmetic section of the datapath as the basic add primitive.

---
 rtl/four_bit_adder.sv | 63 ++++++
 tb/tb_four_bit_adder.sv | 102 ++++++++++
 2 files changed

// File: rtl/four_bit_adder.sv
// four_bit_adder: ripple-carry adder plus registered result; define FOUR_BIT_ADDER_OVF_EN for signed overflow ovf/ovf_q
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module four_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
`ifdef FOUR_BIT_ADDER_OVF_EN
  output logic             ovf,
  output logic             ovf_q,
`endif
  output logic             valid_q
);
  logic [WIDTH:0]   cy;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic             valid_d;
  assign cy[0] = c;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder_cell u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (cy[i]),
      .s   (sum[i]),
      .cout(cy[i+1])
    );
  end
  assign carry = cy[WIDTH];
  always_comb begin
    sum_d   = rst ? '0   : en ? sum   : sum_q;
    carry_d = rst ? 1'b0 : en ? carry : carry_q;
    valid_d = !rst && en;
  end
  always_ff @(posedge clk) begin
    sum_q   <= sum_d;
    carry_q <= carry_d;
    valid_q <= valid_d;
  end
`ifdef FOUR_BIT_ADDER_OVF_EN
  logic ovf_d;
  assign ovf = cy[WIDTH-1] ^ cy[WIDTH];
  always_comb ovf_d = rst ? 1'b0 : en ? ovf : ovf_q;
  always_ff @(posedge clk) ovf_q <= ovf_d;
`endif
endmodule

// File: tb/tb_four_bit_adder.sv
// tb_four_bit_adder: directed checks of the adder's combinational and registered outputs
module tb_four_bit_adder;
  logic       clk = 1'b0;
  logic       rst, en, c;
  logic [3:0] a, b;
  logic [3:0] sum, sum_q;
  logic       carry, carry_q, valid_q;
`ifdef FOUR_BIT_ADDER_OVF_EN
  logic       ovf, ovf_q;
`endif
  int checks = 0;
  int errors = 0;
  four_bit_adder #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .c      (c),
    .sum    (sum),
    .carry  (carry),
    .sum_q  (sum_q),
    .carry_q(carry_q),
`ifdef FOUR_BIT_ADDER_OVF_EN
    .ovf    (ovf),
    .ovf_q  (ovf_q),
`endif
    .valid_q(valid_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; a = 4'd3; b = 4'd5; c = 1'b0;
    #10;
    chk("sum_3_5", {4'b0, sum}, 8'd8);
    chk("carry_3_5", {7'b0, carry}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum_q", {4'b0, sum_q}, 8'd0);
    chk("rst_carry_q", {7'b0, carry_q}, 8'd0);
    chk("rst_valid_q", {7'b0, valid_q}, 8'd0);
    a = 4'd7; b = 4'd9; c = 1'b0; #1;
    chk("sum_7_9", {4'b0, sum}, 8'd0);
    chk("carry_7_9", {7'b0, carry}, 8'd1);
`ifdef FOUR_BIT_ADDER_OVF_EN
    chk("ovf_7_9", {7'b0, ovf}, 8'd0);
`endif
    a = 4'd15; b = 4'd15; c = 1'b1; #1;
    chk("sum_max", {4'b0, sum}, 8'd15);
    chk("carry_max", {7'b0, carry}, 8'd1);
    a = 4'd0; b = 4'd0; c = 1'b1; #1;
    chk("sum_cin_only", {4'b0, sum}, 8'd1);
    chk("carry_cin_only", {7'b0, carry}, 8'd0);
    @(negedge clk);
    rst = 1'b0; a = 4'd6; b = 4'd10; c = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    chk("cap_sum_q", {4'b0, sum_q}, 8'd0);
    chk("cap_carry_q", {7'b0, carry_q}, 8'd1);
    chk("cap_valid_q", {7'b0, valid_q}, 8'd1);
    @(negedge clk);
    en = 1'b0; a = 4'd1; b = 4'd1;
    @(posedge clk); #1;
    chk("hold_sum_q", {4'b0, sum_q}, 8'd0);
    chk("hold_carry_q", {7'b0, carry_q}, 8'd1);
    chk("hold_valid_q", {7'b0, valid_q}, 8'd0);
    @(negedge clk);
    en = 1'b1; a = 4'd9; b = 4'd4;
    @(posedge clk); #1;
    chk("cap2_sum_q", {4'b0, sum_q}, 8'd13);
    chk("cap2_carry_q", {7'b0, carry_q}, 8'd0);
    chk("cap2_valid_q", {7'b0, valid_q}, 8'd1);
    @(negedge clk);
    rst = 1'b1;
    chk("sum_9_4_pre", {4'b0, sum}, 8'd13);
    @(posedge clk); #1;
    chk("rstwin_sum_q", {4'b0, sum_q}, 8'd0);
    chk("rstwin_carry_q", {7'b0, carry_q}, 8'd0);
    chk("rstwin_valid_q", {7'b0, valid_q}, 8'd0);
    chk("sum_9_4_post", {4'b0, sum}, 8'd13);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++) begin
          a = 4'(i); b = 4'(j); c = 1'(k); #1;
          chk("sweep", {3'b0, carry, sum}, 8'(i + j + k));
`ifdef FOUR_BIT_ADDER_OVF_EN
          begin
            int s;
            s = (i > 7 ? i - 16 : i) + (j > 7 ? j - 16 : j) + k;
            chk("sweep_ovf", {7'b0, ovf}, {7'b0, (s > 7 || s < -8)});
          end
`endif
        end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
